alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational alu instance between NUM_REQ requesters, e.g. the execute stage, branch-target adder and load/store address generation.
- Arbitrates round-robin and drives the shared ALU operand/control inputs.
- Captures ALUResult/Zero into a per-requester one-entry response buffer.
- Valid/ready handshake on both request and response sides; one ALU operation per cycle maximum.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..8).
- DATA_WIDTH, 32, operand/result width.
- ALU_CTRL_WIDTH, 4, ALU control code width.
- IDX_WIDTH, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ReqValid  in  NUM_REQ  request valid per requester.
- ReqReady  out  NUM_REQ  request accepted this cycle.
- ReqSrcA  in  NUM_REQ x DATA_WIDTH  operand A per requester.
- ReqSrcB  in  NUM_REQ x DATA_WIDTH  operand B per requester.
- ReqCtrl  in  NUM_REQ x ALU_CTRL_WIDTH  ALU control code per requester.
- ReqPC  in  NUM_REQ x DATA_WIDTH  PC operand per requester.
- RspValid  out  NUM_REQ  response buffer holds a result.
- RspReady  in  NUM_REQ  requester consumes the response.
- RspResult  out  NUM_REQ x DATA_WIDTH  buffered ALUResult.
- RspZero  out  NUM_REQ  buffered Zero flag.
- AluSrcA  out  DATA_WIDTH  to shared ALU SrcA.
- AluSrcB  out  DATA_WIDTH  to shared ALU SrcB.
- AluCtrl  out  ALU_CTRL_WIDTH  to shared ALU ALUControl.
- AluPC  out  DATA_WIDTH  to shared ALU PC.
- AluResult  in  DATA_WIDTH  from shared ALU.
- AluZero  in  1  from shared ALU.
- Busy  out  1  any RspValid set, or any grant this cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Prio pointer is 0.
  - RspValid, RspResult and RspZero are all 0.
  - Registers hold reset values until the first clk edge after deassertion.
- Eligibility:
  - Elig[i] = ReqValid[i] && (!RspValid[i] || RspReady[i]).
  - A full buffer that is being drained in the same cycle counts as free.
- Grant (combinational):
  - Select the first eligible index scanning Prio, Prio+1, ... modulo NUM_REQ.
  - At most one grant per cycle.
  - ReqReady[i] = Grant[i], so a request transfers when ReqValid[i] && ReqReady[i].
- Pointer update:
  - On any grant to index g, Prio <= (g+1) mod NUM_REQ, wrapping NUM_REQ-1 to 0.
  - With no grant, Prio holds.
- ALU drive:
  - With a grant, AluSrcA/AluSrcB/AluCtrl/AluPC are the granted requester's fields, same cycle.
  - With no grant, they are all zero (ALU add, 0+0).
- Capture and latency:
  - On grant g at edge N: RspResult[g] <= AluResult, RspZero[g] <= AluZero, RspValid[g] <= 1.
  - Result is visible from cycle N+1, so latency is 1 cycle.
- Drain:
  - When RspValid[i] && RspReady[i] with no new grant to i, RspValid[i] <= 0.
  - RspResult[i] and RspZero[i] hold their last values.
- Simultaneous drain and grant on the same requester: the new result overwrites and RspValid stays 1, giving a full one-per-cycle stream.
- Backpressure: while RspValid[i] && !RspReady[i], ReqReady[i] = 0, and other requesters are still served.
- Request stability: requesters hold ReqValid and their fields stable until accepted. The arbiter does not check this.
- Fairness: any continuously eligible requester is granted within NUM_REQ cycles.
- Reset mid-operation: pending responses are discarded and no partial state survives.
- Illegal ReqCtrl codes pass through unchanged; the ALU's default behaviour applies.

Decomposition:
- alu_pkg holds:
  - ALU control localparams: ALU_ADD=0000, ALU_SUB=0001, ALU_SLL=0010, ALU_SLT=0011, ALU_SLTU=0100, ALU_XOR=0101, ALU_SRL=0110, ALU_SRA=0111, ALU_OR=1000, ALU_AND=1001, ALU_AUIPC=1010, ALU_LUI=1011, ALU_JAL=1100.
  - Default DATA_WIDTH and ALU_CTRL_WIDTH.
  - A packed struct alu_req_t {SrcA, SrcB, Ctrl, PC}.
- Sub-module rr_arbiter (parameter N):
  - Inputs: elig vector and registered Prio pointer.
  - Outputs: one-hot grant, grant index and any_grant.
- The top level holds the operand mux, response buffers and Busy.

Test Plan:
- Single requester: NUM_REQ=2, req0 valid with SrcA=5, SrcB=3, Ctrl=ALU_ADD, RspReady0=1 -> ReqReady0=1 in cycle 0, then RspValid0=1, RspResult0=8, RspZero0=0 in cycle 1, and RspValid0=0 in cycle 2.
- Contention: both requesters valid every cycle, req0 SUB 7-7, req1 XOR 0xF0^0x0F, ready held high -> grants alternate 0,1,0,1 from reset. req0 gets RspResult=0 with RspZero=1; req1 gets 0xFF with RspZero=0.
- Backpressure: req0 result buffered with RspReady0=0 and req0 valid again -> ReqReady0 stays 0 for 3 cycles while req1 is granted each cycle. Raising RspReady0 re-enables req0 in that same cycle.
- Drain+refill: req0 streams ADD i+1 for i=0..7 with RspReady0=1 -> one result per cycle, RspValid0 never drops, results 1..8 in order.
- Wrap: NUM_REQ=3, all requesters valid -> grant sequence 0,1,2,0,1,2. Dropping req1 gives 0,2,0,2.
- Async reset: assert rst_n low mid-stream between clock edges -> RspValid all 0 and ReqReady all 0 immediately. After release, the first grant goes to index 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU control codes, default widths,
// the request bundle type and the round-robin slot helper.
package alu_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ALU_CTRL_WIDTH = 4;

    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_ADD   = 4'b0000;
    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_SUB   = 4'b0001;
    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_SLL   = 4'b0010;
    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_SLT   = 4'b0011;
    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_SLTU  = 4'b0100;
    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_XOR   = 4'b0101;
    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_SRL   = 4'b0110;
    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_SRA   = 4'b0111;
    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_OR    = 4'b1000;
    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_AND   = 4'b1001;
    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_AUIPC = 4'b1010;
    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_LUI   = 4'b1011;
    localparam logic [DEF_ALU_CTRL_WIDTH-1:0] ALU_JAL   = 4'b1100;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]     SrcA;
        logic [DEF_DATA_WIDTH-1:0]     SrcB;
        logic [DEF_ALU_CTRL_WIDTH-1:0] Ctrl;
        logic [DEF_DATA_WIDTH-1:0]     PC;
    } alu_req_t;

    // Position 'offset' steps after 'base' in a ring of n requesters.
    function automatic int rr_slot(int base, int offset, int n);
        int s;
        s = base + offset;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request, response and shared-ALU bundle between the requesters/ALU (master)
// and the sharing arbiter (slave).
interface alu_share_arbiter_if
    import alu_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ALU_CTRL_WIDTH = DEF_ALU_CTRL_WIDTH
);

    logic [NUM_REQ-1:0]                     ReqValid;
    logic [NUM_REQ-1:0]                     ReqReady;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     ReqSrcA;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     ReqSrcB;
    logic [NUM_REQ-1:0][ALU_CTRL_WIDTH-1:0] ReqCtrl;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     ReqPC;

    logic [NUM_REQ-1:0]                     RspValid;
    logic [NUM_REQ-1:0]                     RspReady;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     RspResult;
    logic [NUM_REQ-1:0]                     RspZero;

    logic [DATA_WIDTH-1:0]                  AluSrcA;
    logic [DATA_WIDTH-1:0]                  AluSrcB;
    logic [ALU_CTRL_WIDTH-1:0]              AluCtrl;
    logic [DATA_WIDTH-1:0]                  AluPC;
    logic [DATA_WIDTH-1:0]                  AluResult;
    logic                                   AluZero;

    logic                                   Busy;

    modport master (
        output ReqValid, ReqSrcA, ReqSrcB, ReqCtrl, ReqPC, RspReady, AluResult, AluZero,
        input  ReqReady, RspValid, RspResult, RspZero, AluSrcA, AluSrcB, AluCtrl, AluPC, Busy
    );

    modport slave (
        input  ReqValid, ReqSrcA, ReqSrcB, ReqCtrl, ReqPC, RspReady, AluResult, AluZero,
        output ReqReady, RspValid, RspResult, RspZero, AluSrcA, AluSrcB, AluCtrl, AluPC, Busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after prio,
// wrapping modulo n.
module rr_arbiter
    import alu_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] prio,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_grant
);

    logic [IW-1:0] slot;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        slot      = '0;
        for (int k = 0; k < N; k++) begin
            slot = IW'(rr_slot(int'(prio), k, N));
            if (!any_grant && elig[slot]) begin
                grant[slot] = 1'b1;
                idx         = slot;
                any_grant   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin
// arbitration and a one-entry response buffer per requester.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ALU_CTRL_WIDTH = DEF_ALU_CTRL_WIDTH,
    parameter int IDX_WIDTH      = $clog2(NUM_REQ)
) (
    input logic               clk,
    input logic               rst_n,
    alu_share_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0]                 elig;
    logic [NUM_REQ-1:0]                 grant;
    logic [IDX_WIDTH-1:0]               gidx;
    logic                               any_grant;
    logic [IDX_WIDTH-1:0]               prio;

    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_result;
    logic [NUM_REQ-1:0]                 rsp_zero;

    logic [DATA_WIDTH-1:0]              alu_a;
    logic [DATA_WIDTH-1:0]              alu_b;
    logic [ALU_CTRL_WIDTH-1:0]          alu_c;
    logic [DATA_WIDTH-1:0]              alu_pc;

    // A buffer being drained this cycle is free; reset blocks every grant immediately.
    assign elig = bus.ReqValid & (~rsp_valid | bus.RspReady) & {NUM_REQ{rst_n}};

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_WIDTH)
    ) u_rr (
        .elig      (elig),
        .prio      (prio),
        .grant     (grant),
        .idx       (gidx),
        .any_grant (any_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= '0;
        end else if (any_grant) begin
            prio <= (gidx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    // A new grant wins over a drain, so a requester can stream one result per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_zero   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    rsp_valid[i]  <= 1'b1;
                    rsp_result[i] <= bus.AluResult;
                    rsp_zero[i]   <= bus.AluZero;
                end else if (bus.RspReady[i]) begin
                    rsp_valid[i]  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_c  = '0;
        alu_pc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_a  = bus.ReqSrcA[i];
                alu_b  = bus.ReqSrcB[i];
                alu_c  = bus.ReqCtrl[i];
                alu_pc = bus.ReqPC[i];
            end
        end
    end

    assign bus.AluSrcA   = alu_a;
    assign bus.AluSrcB   = alu_b;
    assign bus.AluCtrl   = alu_c;
    assign bus.AluPC     = alu_pc;
    assign bus.ReqReady  = grant;
    assign bus.RspValid  = rsp_valid;
    assign bus.RspResult = rsp_result;
    assign bus.RspZero   = rsp_zero;
    assign bus.Busy      = (|rsp_valid) | any_grant;

    grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized scoreboard bench for alu_share_arbiter with three requesters and a
// behavioural stand-in for the shared ALU.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int CW = 4;

    typedef struct {
        logic [DW-1:0] result;
        logic          zero;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ALU_CTRL_WIDTH(CW)) bus ();

    alu_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ALU_CTRL_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;
    bit run        = 1'b0;
    int mode       = 0;

    rsp_t          expq[N][$];
    bit            occ[N];
    int            ptr;
    int            gi;
    int            c;
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  exp_valid;
    logic [DW-1:0] r;
    alu_req_t      rq;
    rsp_t          e;
    logic [N-1:0]  acc;

    function automatic logic [DW-1:0] alu_ref(alu_req_t q);
        case (q.Ctrl)
            ALU_ADD:   return q.SrcA + q.SrcB;
            ALU_SUB:   return q.SrcA - q.SrcB;
            ALU_SLL:   return q.SrcA << q.SrcB[4:0];
            ALU_SLT:   return ($signed(q.SrcA) < $signed(q.SrcB)) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (q.SrcA < q.SrcB) ? 32'd1 : 32'd0;
            ALU_XOR:   return q.SrcA ^ q.SrcB;
            ALU_SRL:   return q.SrcA >> q.SrcB[4:0];
            ALU_SRA:   return $unsigned($signed(q.SrcA) >>> q.SrcB[4:0]);
            ALU_OR:    return q.SrcA | q.SrcB;
            ALU_AND:   return q.SrcA & q.SrcB;
            ALU_AUIPC: return q.PC + q.SrcB;
            ALU_LUI:   return q.SrcB;
            ALU_JAL:   return q.PC + 32'd4;
            default:   return '0;
        endcase
    endfunction

    // The shared ALU the arbiter drives.
    always_comb begin
        bus.AluResult = alu_ref('{SrcA: bus.AluSrcA, SrcB: bus.AluSrcB, Ctrl: bus.AluCtrl, PC: bus.AluPC});
        bus.AluZero   = (bus.AluResult == '0);
    end

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Modes: 0 random, 1 heavy backpressure on req0, 2 all valid, 3 all valid but req1 idle.
    task automatic applyStimulus(logic [N-1:0] accepted);
        for (int i = 0; i < N; i++) begin
            if (!(bus.ReqValid[i] && !accepted[i])) begin
                bit v;
                logic [DW-1:0] a;
                case (mode)
                    2:       v = 1'b1;
                    3:       v = (i != 1);
                    default: v = ($urandom % 3) != 0;
                endcase
                a = $urandom;
                bus.ReqValid[i] = v;
                bus.ReqSrcA[i]  = a;
                bus.ReqSrcB[i]  = ($urandom % 4 == 0) ? a : DW'($urandom);
                bus.ReqCtrl[i]  = CW'($urandom % 16);
                bus.ReqPC[i]    = $urandom;
            end
            if (mode == 2 || mode == 3)
                bus.RspReady[i] = 1'b1;
            else if (mode == 1 && i == 0)
                bus.RspReady[i] = ($urandom % 8 == 0);
            else
                bus.RspReady[i] = ($urandom % 4 != 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            acc = bus.ReqValid & bus.ReqReady;
            @(posedge clk);
            #1;
            if (run) applyStimulus(acc);
        end
    end

    // Reference model: round-robin pointer, buffer occupancy and expected-response queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            ptr = 0;
            for (int i = 0; i < N; i++) begin
                occ[i] = 1'b0;
                expq[i].delete();
            end
        end else begin
            gi = -1;
            for (int k = 0; k < N; k++) begin
                c = (ptr + k) % N;
                if (gi < 0 && bus.ReqValid[c] && (!occ[c] || bus.RspReady[c])) gi = c;
            end
            exp_ready = '0;
            for (int i = 0; i < N; i++) exp_valid[i] = occ[i];
            rq = '0;
            if (gi >= 0) begin
                exp_ready[gi] = 1'b1;
                rq.SrcA = bus.ReqSrcA[gi];
                rq.SrcB = bus.ReqSrcB[gi];
                rq.Ctrl = bus.ReqCtrl[gi];
                rq.PC   = bus.ReqPC[gi];
            end
            checkOutput("ReqReady", 64'(bus.ReqReady), 64'(exp_ready));
            checkOutput("RspValid", 64'(bus.RspValid), 64'(exp_valid));
            checkOutput("Busy", 64'(bus.Busy), 64'((exp_valid != '0) || (gi >= 0)));
            checkOutput("AluSrcAB", {bus.AluSrcA, bus.AluSrcB}, {rq.SrcA, rq.SrcB});
            checkOutput("AluCtrlPC", 64'({bus.AluCtrl, bus.AluPC}), 64'({rq.Ctrl, rq.PC}));
            for (int i = 0; i < N; i++)
                if (occ[i] && bus.RspReady[i]) occ[i] = 1'b0;
            if (gi >= 0) begin
                occ[gi] = 1'b1;
                r = alu_ref(rq);
                expq[gi].push_back('{result: r, zero: (r == '0)});
                ptr = (gi + 1) % N;
            end
        end
    end

    // Monitor: every consumed response is checked against the oldest expected one.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (bus.RspValid[i] && bus.RspReady[i]) begin
                    if (expq[i].size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL RspUnexpected: got response on req%0d, required none at %0t", i, $time);
                    end else begin
                        e = expq[i].pop_front();
                        checkOutput("RspResult", 64'(bus.RspResult[i]), 64'(e.result));
                        checkOutput("RspZero", 64'(bus.RspZero[i]), 64'(e.zero));
                    end
                end
            end
        end
    end

    initial begin
        bus.ReqValid = '1;
        bus.ReqSrcA  = '0;
        bus.ReqSrcB  = '0;
        bus.ReqCtrl  = '0;
        bus.ReqPC    = '0;
        bus.RspReady = '0;
        #12;
        checkOutput("ResetReqReady", 64'(bus.ReqReady), 64'(0));
        checkOutput("ResetRspValid", 64'(bus.RspValid), 64'(0));
        checkOutput("ResetRspResult", 64'(bus.RspResult), 64'(0));
        checkOutput("ResetBusy", 64'(bus.Busy), 64'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        run = 1'b1;
        mode = 2; repeat (40)  @(posedge clk);
        mode = 3; repeat (40)  @(posedge clk);
        mode = 1; repeat (200) @(posedge clk);
        mode = 0; repeat (800) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("MidResetReqReady", 64'(bus.ReqReady), 64'(0));
        checkOutput("MidResetRspValid", 64'(bus.RspValid), 64'(0));
        checkOutput("MidResetBusy", 64'(bus.Busy), 64'(0));
        checkOutput("MidResetAluSrcA", 64'(bus.AluSrcA), 64'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        mode = 2; repeat (20)  @(posedge clk);
        mode = 0; repeat (500) @(posedge clk);
        run = 1'b0;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
